counter_arb: RTL and testbench
==============================

# counter_arb

Round-robin controller that shares a single toggle-accumulate counter engine (ports e, clr, q) between two requesters, A and B. Each requester asks for a burst of enabled counter cycles, optionally preceded by a clear. The block sequences the engine's e/clr inputs for that burst and returns the engine's final q as a captured result. It sits between the requesting logic and the one counter instance, which it alone drives.

## Interface
- LEN_W, 4: width of burst-length fields; bursts range from 0 to 2^LEN_W-1 enabled cycles.
- clk  in  1  rising-edge clock, shared with the counter engine.
- clr_n  in  1  synchronous active-low reset.
- req_a / req_b  in  1  request level; sampled only in IDLE.
- clr_a / clr_b  in  1  clear the engine before the burst; sampled together with the request.
- len_a / len_b  in  LEN_W  number of enabled accumulate cycles; sampled together with the request.
- gnt_a / gnt_b  out  1  requester owns the engine (CLEAR, RUN and CAPT states).
- done_a / done_b  out  1  one-cycle pulse; result is valid.
- result  out  8  engine q captured at the end of the granted transaction; holds until the next capture.
- busy  out  1  high in any state other than IDLE.
- cnt_e  out  1  drives engine e.
- cnt_clr  out  1  drives engine clr.
- cnt_q  in  8  engine q.

## Operation
- Engine model, for the bench:
  - On a clk edge with e=1 and clr=1: r←0xAA, q←0x00.
  - On a clk edge with e=1 and clr=0: q←q+r (mod 256), and every bit of r inverts.
  - On a clk edge with e=0: no change.
  - The engine has no reset; its contents are unknown until a clear transaction.
- FSM states: IDLE, CLEAR, RUN, CAPT, DONE.
- IDLE:
  - If any request is high, arbitrate.
  - Latch the winner's clr_x and len_x into internal registers, and set owner and last_served to the winner.
  - Next state is CLEAR if clr=1, else RUN if len≠0, else CAPT.
- Arbitration:
  - A single request wins.
  - If both requests are high, the requester not equal to last_served wins.
- CLEAR: cnt_e=1, cnt_clr=1 for one cycle. Next state is RUN if len≠0, else CAPT.
- RUN:
  - cnt_e=1, cnt_clr=0.
  - A down-counter is loaded with len and decrements each cycle.
  - Stay in RUN for exactly len cycles, then go to CAPT.
- CAPT:
  - cnt_e=0; cnt_q is final.
  - result←cnt_q at the closing edge. Next state is DONE.
- DONE:
  - done_owner=1 and both gnt=0.
  - Requests are ignored. Next state is IDLE.
- Requester protocol:
  - Hold req, clr and len stable until the grant is seen.
  - Deassert req no later than the done cycle.
  - A req still high in the following IDLE cycle is treated as a new transaction.
- cnt_e and cnt_clr are decoded from the state only; they are never high in IDLE or DONE.
- Engine state persists between transactions. A clr=0 burst continues from the previous owner's q and r.

## Timing
- Reset (clr_n=0 at an edge):
  - state←IDLE, last_served←B (so A wins the first tie).
  - gnt_a=gnt_b=0, done_a=done_b=0, busy=0, cnt_e=0, cnt_clr=0, result←0x00.
- Reset mid-transaction aborts the transaction:
  - The engine stops receiving enables on the next cycle.
  - No done pulse is issued for the aborted transaction.
- Cycle 0 is the IDLE cycle in which a request is sampled. Latency from there:
  - With clr=1: CLEAR in cycle 1, RUN in cycles 2…len+1, CAPT in cycle len+2, done in cycle len+3.
  - With clr=0: done in cycle len+2.
  - With clr=0 and len=0: done in cycle 2.
- Grant is high from cycle 1 through the CAPT cycle inclusive.
- Back-to-back transactions take a minimum of one IDLE cycle between DONE and the next CLEAR/RUN.
- Widths:
  - The len counter is LEN_W bits; the maximum length runs 2^LEN_W-1 cycles with no wrap.
  - result wraps modulo 256 because the engine does.

## Test plan
- Reset, then req_a=1, clr_a=1, len_a=2 → gnt_a in cycles 1–4, cnt_clr only in cycle 1, cnt_e in cycles 1–3, done_a in cycle 5, result=0xFF.
- A with clr=1, len=3 → result=0xA9 (0xFF+0xAA wraps), exercising overflow.
- A with clr=1, len=1 (result 0xAA); then B with clr=0, len=1 → B's result=0xFF, confirming engine state carries across owners.
- req_a and req_b raised in the same cycle after reset, each with clr=1, len=0 → A served first (result 0x00, done_a); B served next after one IDLE cycle; a further simultaneous pair goes to A again only after B.
- clr=0, len=0 → no cnt_e cycles, done two cycles after the request, result equals cnt_q unchanged.
- clr_n pulsed low during the RUN of a len=15 burst → next cycle cnt_e=0, gnt=0, done never pulses, result=0x00; a fresh clr=1, len=2 request afterwards yields 0xFF.

Source files
------------

// File: rtl/counter_arb.sv
// counter_arb: round-robin owner of a single toggle-accumulate counter engine.
// Two requesters (A, B) each ask for an optional clear followed by a burst of
// enabled counter cycles. The block drives the engine's e/clr inputs for the
// burst and captures the engine's final q as the transaction result.
module counter_arb #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_a,
  input  logic             clr_a,
  input  logic [LEN_W-1:0] len_a,
  input  logic             req_b,
  input  logic             clr_b,
  input  logic [LEN_W-1:0] len_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [7:0]       result,
  output logic             busy,
  output logic             cnt_e,
  output logic             cnt_clr,
  input  logic [7:0]       cnt_q
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPT,
    DONE
  } state_t;

  typedef enum logic {
    SEL_A,
    SEL_B
  } sel_t;

  state_t           state;
  sel_t             owner;
  sel_t             last_served;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] run_cnt;

  sel_t             winner;
  logic             win_clr;
  logic [LEN_W-1:0] win_len;

  // Pick the requester to serve this IDLE cycle: a lone request wins, a tie
  // goes to whoever was not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    winner = SEL_A;
    if (req_b && (!req_a || last_served == SEL_A)) begin
      winner = SEL_B;
    end
    win_clr = (winner == SEL_B) ? clr_b : clr_a;
    win_len = (winner == SEL_B) ? len_b : len_a;
  end

  // Transaction sequencer; all outputs are registered alongside the state so
  // each output reflects the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!clr_n) begin
      state       <= IDLE;
      owner       <= SEL_A;
      last_served <= SEL_B;
      len_q       <= '0;
      run_cnt     <= '0;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      busy        <= 1'b0;
      cnt_e       <= 1'b0;
      cnt_clr     <= 1'b0;
      result      <= 8'h00;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_a || req_b) begin
            owner       <= winner;
            last_served <= winner;
            len_q       <= win_len;
            run_cnt     <= win_len;
            gnt_a       <= (winner == SEL_A);
            gnt_b       <= (winner == SEL_B);
            busy        <= 1'b1;
            if (win_clr) begin
              state   <= CLEAR;
              cnt_e   <= 1'b1;
              cnt_clr <= 1'b1;
            end else if (win_len != '0) begin
              state   <= RUN;
              cnt_e   <= 1'b1;
              cnt_clr <= 1'b0;
            end else begin
              state   <= CAPT;
              cnt_e   <= 1'b0;
              cnt_clr <= 1'b0;
            end
          end
        end
        CLEAR: begin
          cnt_clr <= 1'b0;
          if (len_q != '0) begin
            state   <= RUN;
            cnt_e   <= 1'b1;
            run_cnt <= len_q;
          end else begin
            state <= CAPT;
            cnt_e <= 1'b0;
          end
        end
        RUN: begin
          // run_cnt is never zero here: RUN is only entered with len != 0.
          if (run_cnt == LEN_W'(1)) begin
            state <= CAPT;
            cnt_e <= 1'b0;
          end else begin
            run_cnt <= run_cnt - LEN_W'(1);
          end
        end
        CAPT: begin
          result <= cnt_q;
          state  <= DONE;
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          done_a <= (owner == SEL_A);
          done_b <= (owner == SEL_B);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          busy    <= 1'b0;
          cnt_e   <= 1'b0;
          cnt_clr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arb.sv
// Directed testbench for counter_arb with a behavioural model of the shared
// toggle-accumulate counter engine.
module tb_counter_arb;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             req_a, clr_a, req_b, clr_b;
  logic [LEN_W-1:0] len_a, len_b;
  logic             gnt_a, gnt_b, done_a, done_b, busy, cnt_e, cnt_clr;
  logic [7:0]       result, cnt_q;

  logic [7:0]       eng_r;
  logic [7:0]       eng_q;

  int tests_run = 0;
  int tests_failed = 0;

  counter_arb #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .req_a   (req_a),
    .clr_a   (clr_a),
    .len_a   (len_a),
    .req_b   (req_b),
    .clr_b   (clr_b),
    .len_b   (len_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .done_a  (done_a),
    .done_b  (done_b),
    .result  (result),
    .busy    (busy),
    .cnt_e   (cnt_e),
    .cnt_clr (cnt_clr),
    .cnt_q   (cnt_q)
  );

  always #5 clk = ~clk;

  // Counter engine: no reset, clear loads r=0xAA/q=0, enable accumulates and toggles r.
  always @(posedge clk) begin
    if (cnt_e) begin
      if (cnt_clr) begin
        eng_r <= 8'hAA;
        eng_q <= 8'h00;
      end else begin
        eng_q <= eng_q + eng_r;
        eng_r <= ~eng_r;
      end
    end
  end
  assign cnt_q = eng_q;

  // Observed control vector: {gnt_a, gnt_b, cnt_e, cnt_clr, done_a, done_b, busy}
  function automatic logic [6:0] obs();
    return {gnt_a, gnt_b, cnt_e, cnt_clr, done_a, done_b, busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    req_a = 1'b0; clr_a = 1'b0; len_a = '0;
    req_b = 1'b0; clr_b = 1'b0; len_b = '0;
    step();
    step();
    tests_run++;
    if (obs() !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required %b", obs(), 7'b0000000);
    end
    tests_run++;
    if (result !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_result: got %h required %h", result, 8'h00);
    end
    clr_n = 1'b1;
    step();
  endtask

  // One full transaction from the IDLE cycle; checks every cycle's controls
  // against the documented latency, the result at done, and the IDLE after.
  task automatic do_txn(input bit who, input bit c, input logic [LEN_W-1:0] l,
                        input logic [7:0] exp_res, input string name);
    int d;
    logic [6:0] exp;
    bit e_exp;
    d = c ? int'(l) + 3 : int'(l) + 2;
    if (who == 1'b0) begin req_a = 1'b1; clr_a = c; len_a = l; end
    else             begin req_b = 1'b1; clr_b = c; len_b = l; end
    for (int k = 1; k <= d + 1; k++) begin
      step();
      e_exp = c ? (k <= int'(l) + 1) : (k <= int'(l));
      exp = {(who == 1'b0) && (k < d), (who == 1'b1) && (k < d),
             e_exp && (k < d), c && (k == 1),
             (who == 1'b0) && (k == d), (who == 1'b1) && (k == d), k <= d};
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL %s_ctrl_cyc%0d: got %b required %b", name, k, obs(), exp);
      end
      if (k == d) begin
        tests_run++;
        if (result !== exp_res) begin
          tests_failed++;
          $display("FAIL %s_result: got %h required %h", name, result, exp_res);
        end
      end
      if (k == 1) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
  endtask

  task automatic test_basic();
    do_txn(1'b0, 1'b1, 4'd2, 8'hFF, "basic_a_clr_len2");
  endtask

  task automatic test_overflow();
    do_txn(1'b0, 1'b1, 4'd3, 8'hA9, "overflow_len3");
  endtask

  task automatic test_carry_owner();
    do_txn(1'b0, 1'b1, 4'd1, 8'hAA, "carry_a_len1");
    do_txn(1'b1, 1'b0, 4'd1, 8'hFF, "carry_b_noclr");
  endtask

  task automatic test_zero_len();
    // Engine holds q=0xFF from the previous burst; nothing should change it.
    do_txn(1'b0, 1'b0, 4'd0, 8'hFF, "zero_len_noclr");
  endtask

  task automatic test_max_len();
    // 8 x 0xAA + 7 x 0x55 = 1955 = 0xA3 mod 256.
    do_txn(1'b1, 1'b1, 4'd15, 8'hA3, "max_len15");
  endtask

  task automatic test_arbitration();
    logic [6:0] exp_tab [1:11];
    exp_tab[1]  = 7'b1011001;
    exp_tab[2]  = 7'b1000001;
    exp_tab[3]  = 7'b0000101;
    exp_tab[4]  = 7'b0000000;
    exp_tab[5]  = 7'b0111001;
    exp_tab[6]  = 7'b0100001;
    exp_tab[7]  = 7'b0000011;
    exp_tab[8]  = 7'b0000000;
    exp_tab[9]  = 7'b1011001;
    exp_tab[10] = 7'b1000001;
    exp_tab[11] = 7'b0000101;
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    req_a = 1'b1; clr_a = 1'b1; len_a = 4'd0;
    req_b = 1'b1; clr_b = 1'b1; len_b = 4'd0;
    for (int k = 1; k <= 11; k++) begin
      step();
      tests_run++;
      if (obs() !== exp_tab[k]) begin
        tests_failed++;
        $display("FAIL arb_ctrl_cyc%0d: got %b required %b", k, obs(), exp_tab[k]);
      end
      if (k == 3 || k == 7 || k == 11) begin
        tests_run++;
        if (result !== 8'h00) begin
          tests_failed++;
          $display("FAIL arb_result_cyc%0d: got %h required %h", k, result, 8'h00);
        end
      end
      case (k)
        1: req_a = 1'b0;
        2: req_a = 1'b1;
        5: req_b = 1'b0;
        7: req_b = 1'b1;
        9: begin req_a = 1'b0; req_b = 1'b0; end
        default: ;
      endcase
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit bad;
    req_a = 1'b1; clr_a = 1'b1; len_a = 4'd15;
    step();
    req_a = 1'b0;
    step();
    step();
    step();
    tests_run++;
    if (cnt_e !== 1'b1 || gnt_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_in_run: got e=%b gnt=%b required e=1 gnt=1", cnt_e, gnt_a);
    end
    clr_n = 1'b0;
    step();
    tests_run++;
    if (obs() !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL rstmid_ctrl: got %b required %b", obs(), 7'b0000000);
    end
    tests_run++;
    if (result !== 8'h00) begin
      tests_failed++;
      $display("FAIL rstmid_result: got %h required %h", result, 8'h00);
    end
    clr_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs() !== 7'b0000000) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: got activity after abort required none");
    end
    do_txn(1'b0, 1'b1, 4'd2, 8'hFF, "rstmid_fresh");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_carry_owner();
    test_zero_len();
    test_arbitration();
    test_max_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
